// File: rtl/prover_collapse_v_pkg.sv
// -----------------------------------------------------------------------------
// prover_collapse_v_pkg
// Shared types and helpers for the V-table collapse (fold) engine.
//   state_t      : controller states IDLE / LOAD / FOLD / OUT
//   clamp_levels : limits a requested fold-level count to log2(NVALS)
// Field parameters `F_NBITS and `F_Q normally come from field_arith_defs.v;
// the guarded defaults below only apply when that file was not read first.
// -----------------------------------------------------------------------------
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 16'd65521
`endif

package prover_collapse_v_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FOLD = 2'd2,
      OUT  = 2'd3
   } state_t;

   // Requests beyond log2(NVALS) would fold past a single element.
   function automatic int unsigned clamp_levels(input int unsigned lev,
                                                input int unsigned max_lev);
      if (lev > max_lev) begin
         return max_lev;
      end else begin
         return lev;
      end
   endfunction

endpackage

// File: rtl/prover_collapse_v_addmod.sv
// -----------------------------------------------------------------------------
// prover_collapse_v_addmod
// Combinational modular adder: sum = (a + b) mod `F_Q, both inputs < `F_Q.
// Ports:
//   a, b  in  `F_NBITS  operands
//   sum   out `F_NBITS  reduced sum, always < `F_Q
// -----------------------------------------------------------------------------
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 16'd65521
`endif

module prover_collapse_v_addmod
   import prover_collapse_v_pkg::*;
(
   input  logic [`F_NBITS-1:0] a,
   input  logic [`F_NBITS-1:0] b,
   output logic [`F_NBITS-1:0] sum
);

   logic [`F_NBITS:0] w_s;
   logic [`F_NBITS:0] w_q;

   // One extra bit keeps the carry so a single conditional subtract reduces.
   always_comb begin
      w_q = {1'b0, `F_Q};
      w_s = {1'b0, a} + {1'b0, b};
      if (w_s >= w_q) begin
         sum = `F_NBITS'(w_s - w_q);
      end else begin
         sum = w_s[`F_NBITS-1:0];
      end
   end

endmodule

// File: rtl/prover_collapse_v.sv
// -----------------------------------------------------------------------------
// prover_collapse_v
// Sequential fold engine for the sum-check prover V table. Loads NVALS field
// elements, collapses adjacent pairs by modular addition for a programmable
// number of levels, then streams the shortened vector out.
// Optional feature macro: PROVER_COLLAPSE_V_DUPCHECK_EN
//   defined   -> dup_err flags any folded pair whose halves differ (sticky)
//   undefined -> dup_err tied low, no comparator
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, levels     job start (IDLE only) and requested fold levels
//   in_data/valid/ready   input stream (accepted in LOAD)
//   out_data/valid/ready  output stream (driven in OUT)
//   busy              high whenever not IDLE
//   done              one-cycle pulse after the final output handshake
//   dup_err           sticky duplicate-mismatch flag
// -----------------------------------------------------------------------------
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 16'd65521
`endif

module prover_collapse_v
   import prover_collapse_v_pkg::*;
#(
   parameter int NVALS = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(NVALS)-1:0]   levels,
   input  logic [`F_NBITS-1:0]        in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [`F_NBITS-1:0]        out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done,
   output logic                       dup_err
);

   localparam int LW = $clog2(NVALS);
   localparam int NW = LW + 1;

   state_t              r_state;
   logic [`F_NBITS-1:0] r_mem [NVALS];
   logic [LW-1:0]       r_cnt;
   logic [LW-1:0]       r_lev_left;
   logic [NW-1:0]       r_len;
   logic                r_done;

   logic [LW-1:0]       w_idx0;
   logic [LW-1:0]       w_idx1;
   logic [LW-1:0]       w_half_m1;
   logic [LW-1:0]       w_len_m1;
   logic [LW-1:0]       w_lev_clamped;
   logic [`F_NBITS-1:0] w_a;
   logic [`F_NBITS-1:0] w_b;
   logic [`F_NBITS-1:0] w_sum;

   // Pair addressing and loop bounds for the current level.
   always_comb begin
      w_idx0        = LW'({1'b0, r_cnt} << 1);
      w_idx1        = w_idx0 | LW'(1);
      w_half_m1     = LW'((r_len >> 1) - NW'(1));
      w_len_m1      = LW'(r_len - NW'(1));
      w_lev_clamped = LW'(clamp_levels(32'(levels), LW));
      w_a           = r_mem[w_idx0];
      w_b           = r_mem[w_idx1];
   end

   prover_collapse_v_addmod u_addmod (
      .a   (w_a),
      .b   (w_b),
      .sum (w_sum)
   );

   // Controller: load, in-place fold (reads at >= cnt, write at cnt), drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_len      <= '0;
         r_lev_left <= '0;
         r_done     <= 1'b0;
         for (int i = 0; i < NVALS; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_lev_left <= w_lev_clamped;
                  r_len      <= NW'(NVALS);
                  r_cnt      <= '0;
                  r_state    <= LOAD;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  r_mem[r_cnt] <= in_data;
                  if (r_cnt == LW'(NVALS - 1)) begin
                     r_cnt   <= '0;
                     r_state <= (r_lev_left != '0) ? FOLD : OUT;
                  end else begin
                     r_cnt <= r_cnt + LW'(1);
                  end
               end
            end
            FOLD: begin
               r_mem[r_cnt] <= w_sum;
               if (r_cnt == w_half_m1) begin
                  // Level boundary: next level starts on the following cycle.
                  r_len      <= r_len >> 1;
                  r_lev_left <= r_lev_left - LW'(1);
                  r_cnt      <= '0;
                  if (r_lev_left == LW'(1)) begin
                     r_state <= OUT;
                  end
               end else begin
                  r_cnt <= r_cnt + LW'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  if (r_cnt == w_len_m1) begin
                     r_cnt   <= '0;
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + LW'(1);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef PROVER_COLLAPSE_V_DUPCHECK_EN
   logic r_dup_err;

   // Sticky mismatch flag; a fresh job clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dup_err <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_dup_err <= 1'b0;
      end else if (r_state == FOLD && w_a != w_b) begin
         r_dup_err <= 1'b1;
      end else begin
         r_dup_err <= r_dup_err;
      end
   end

   assign dup_err = r_dup_err;
`else
   assign dup_err = 1'b0;
`endif

   // Handshake flags decode straight from state; data only shown in OUT.
   always_comb begin
      in_ready  = (r_state == LOAD);
      out_valid = (r_state == OUT);
      busy      = (r_state != IDLE);
      done      = r_done;
      if (r_state == OUT) begin
         out_data = r_mem[r_cnt];
      end else begin
         out_data = '0;
      end
   end

endmodule

// File: tb/tb_prover_collapse_v.sv
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 16'd65521
`endif

module tb_prover_collapse_v;

   typedef logic [15:0] vec_t [8];

   localparam logic [15:0] Q = `F_Q;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  levels = 3'd0;
   logic [15:0] in_data = 16'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy;
   logic        done;
   logic        dup_err;

   int checks = 0;
   int errors = 0;

   prover_collapse_v #(.NVALS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .levels    (levels),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .dup_err   (dup_err)
   );

   always #5 clk = ~clk;

   // Start a job; returns at the negedge of the first LOAD cycle.
   task automatic do_start(input logic [2:0] lev);
      start  = 1'b1;
      levels = lev;
      @(negedge clk);
      start  = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_to_load got in_ready=%0b busy=%0b expected 1 1", in_ready, busy);
      end
   endtask

   // Feed 8 elements (optional in_valid gaps), then count FOLD cycles.
   task automatic do_load_fold(input vec_t v, input bit gaps,
                               output int fold, output int dup_at, output bit to);
      for (int i = 0; i < 8; i++) begin
         if (gaps && i[0]) begin
            in_valid = 1'b0;
            in_data  = 16'd999;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = v[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      fold   = 0;
      dup_at = 0;
      while (!out_valid && fold < 100) begin
         fold++;
         if (dup_err && dup_at == 0) dup_at = fold;
         @(negedge clk);
      end
      to = !out_valid;
   endtask

   // Drain n outputs; with toggle, out_ready is random and stalls are checked.
   task automatic do_collect(input int n, input bit toggle, output vec_t got, output bit to);
      int k = 0;
      int guard = 0;
      logic [15:0] held = 16'd0;
      bit stalled = 1'b0;
      got = '{default: 16'd0};
      while (k < n && guard < 300) begin
         if (stalled) begin
            checks++;
            if (out_data !== held || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold got %0d valid %0b expected %0d valid 1", out_data, out_valid, held);
            end
         end
         out_ready = toggle ? ((guard == 0) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
         if (out_valid && out_ready) begin
            got[k] = out_data;
            k++;
            stalled = 1'b0;
         end else if (out_valid) begin
            held    = out_data;
            stalled = 1'b1;
         end else begin
            stalled = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      out_ready = 1'b1;
      to = (k < n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0 ||
          busy !== 1'b0 || done !== 1'b0 || dup_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got ir=%0b ov=%0b od=%0d busy=%0b done=%0b dup=%0b expected all 0",
                  in_ready, out_valid, out_data, busy, done, dup_err);
      end
   endtask

   task automatic test_fold1();
      vec_t v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      vec_t e = '{16'd3, 16'd7, 16'd11, 16'd15, 16'd0, 16'd0, 16'd0, 16'd0};
      vec_t got;
      int fold, dup_at;
      bit to1, to2;
      do_start(3'd1);
      do_load_fold(v, 1'b0, fold, dup_at, to1);
      checks++;
      if (to1 || fold != 4) begin
         errors++;
         $display("FAIL fold1_cycles got %0d timeout %0b expected 4", fold, to1);
      end
      do_collect(4, 1'b0, got, to2);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (to2 || got[i] !== e[i]) begin
            errors++;
            $display("FAIL fold1_out[%0d] got %0d expected %0d", i, got[i], e[i]);
         end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL fold1_done got done=%0b busy=%0b expected 1 0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL fold1_done_pulse got %0b expected 0", done);
      end
   endtask

   task automatic test_fold_full(input logic [2:0] lev, input string name);
      vec_t v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      vec_t got;
      int fold, dup_at;
      bit to1, to2;
      do_start(lev);
      do_load_fold(v, 1'b0, fold, dup_at, to1);
      checks++;
      if (to1 || fold != 7) begin
         errors++;
         $display("FAIL %s_cycles got %0d expected 7", name, fold);
      end
      do_collect(1, 1'b0, got, to2);
      checks++;
      if (to2 || got[0] !== 16'd36 || done !== 1'b1) begin
         errors++;
         $display("FAIL %s_out got %0d done %0b expected 36 done 1", name, got[0], done);
      end
   endtask

   task automatic test_wrap();
      vec_t v = '{Q - 16'd1, 16'd2, Q - 16'd1, Q - 16'd1, 16'd0, 16'd0, 16'd3, 16'd4};
      vec_t e = '{16'd1, Q - 16'd2, 16'd0, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0};
      vec_t got;
      int fold, dup_at;
      bit to1, to2;
      do_start(3'd1);
      do_load_fold(v, 1'b0, fold, dup_at, to1);
      do_collect(4, 1'b0, got, to2);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (to1 || to2 || got[i] !== e[i]) begin
            errors++;
            $display("FAIL wrap_out[%0d] got %0d expected %0d", i, got[i], e[i]);
         end
      end
   endtask

   task automatic test_buffer();
      vec_t v;
      vec_t got;
      int fold, dup_at;
      bit to1, to2;
      for (int i = 0; i < 8; i++) v[i] = 16'($urandom_range(0, 65520));
      do_start(3'd0);
      do_load_fold(v, 1'b1, fold, dup_at, to1);
      checks++;
      if (to1 || fold != 0) begin
         errors++;
         $display("FAIL buffer_cycles got %0d expected 0", fold);
      end
      do_collect(8, 1'b1, got, to2);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (to2 || got[i] !== v[i]) begin
            errors++;
            $display("FAIL buffer_out[%0d] got %0d expected %0d", i, got[i], v[i]);
         end
      end
   endtask

   task automatic test_rst_fold();
      vec_t v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      vec_t e = '{16'd3, 16'd7, 16'd11, 16'd15, 16'd0, 16'd0, 16'd0, 16'd0};
      vec_t got;
      bit to2;
      do_start(3'd3);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = v[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0 ||
          busy !== 1'b0 || done !== 1'b0 || dup_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_abort got ir=%0b ov=%0b od=%0d busy=%0b done=%0b expected all 0",
                  in_ready, out_valid, out_data, busy, done);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_resume got ov=%0b busy=%0b expected 0 0", out_valid, busy);
      end
      do_start(3'd1);
      begin
         int fold, dup_at;
         bit to1;
         do_load_fold(v, 1'b0, fold, dup_at, to1);
      end
      do_collect(4, 1'b0, got, to2);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (to2 || got[i] !== e[i]) begin
            errors++;
            $display("FAIL rst_rerun_out[%0d] got %0d expected %0d", i, got[i], e[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      vec_t v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      vec_t got;
      int fold, dup_at;
      bit to1, to2;
      do_start(3'd3);
      do_load_fold(v, 1'b0, fold, dup_at, to1);
      do_collect(1, 1'b0, got, to2);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done got %0b expected 1", done);
      end
      do_start(3'd2);
      do_load_fold(v, 1'b0, fold, dup_at, to1);
      checks++;
      if (to1 || fold != 6) begin
         errors++;
         $display("FAIL b2b_cycles got %0d expected 6", fold);
      end
      do_collect(2, 1'b0, got, to2);
      checks++;
      if (to2 || got[0] !== 16'd10 || got[1] !== 16'd26) begin
         errors++;
         $display("FAIL b2b_out got %0d,%0d expected 10,26", got[0], got[1]);
      end
   endtask

   task automatic test_dup();
      vec_t v1 = '{16'd5, 16'd5, 16'd6, 16'd6, 16'd7, 16'd7, 16'd8, 16'd8};
      vec_t v2 = '{16'd5, 16'd5, 16'd6, 16'd9, 16'd1, 16'd1, 16'd2, 16'd2};
      vec_t got;
      int fold, dup_at;
      int exp_at;
      logic exp_dup;
      bit to1, to2;
`ifdef PROVER_COLLAPSE_V_DUPCHECK_EN
      exp_at  = 3;
      exp_dup = 1'b1;
`else
      exp_at  = 0;
      exp_dup = 1'b0;
`endif
      do_start(3'd1);
      do_load_fold(v1, 1'b0, fold, dup_at, to1);
      do_collect(4, 1'b0, got, to2);
      checks++;
      if (to2 || dup_at != 0 || dup_err !== 1'b0 || got[0] !== 16'd10 || got[3] !== 16'd16) begin
         errors++;
         $display("FAIL dup_clean got dup_at=%0d dup=%0b out0=%0d out3=%0d expected 0 0 10 16",
                  dup_at, dup_err, got[0], got[3]);
      end
      do_start(3'd1);
      do_load_fold(v2, 1'b0, fold, dup_at, to1);
      checks++;
      if (dup_at != exp_at) begin
         errors++;
         $display("FAIL dup_first_cycle got %0d expected %0d", dup_at, exp_at);
      end
      do_collect(4, 1'b0, got, to2);
      checks++;
      if (dup_err !== exp_dup || got[1] !== 16'd15) begin
         errors++;
         $display("FAIL dup_sticky got dup=%0b out1=%0d expected %0b 15", dup_err, got[1], exp_dup);
      end
      do_start(3'd1);
      checks++;
      if (dup_err !== 1'b0) begin
         errors++;
         $display("FAIL dup_clear got %0b expected 0", dup_err);
      end
      do_load_fold(v1, 1'b0, fold, dup_at, to1);
      do_collect(4, 1'b0, got, to2);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fold1();
      test_fold_full(3'd3, "fold3");
      test_fold_full(3'd7, "clamp");
      test_wrap();
      test_buffer();
      test_rst_fold();
      test_back_to_back();
      test_dup();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
